axis_sample_packer: RTL and testbench
=====================================

# axis_sample_packer

Packs a stream of narrow AXI-Stream samples into wide words, RATIO samples per output word, with packet-end and flush handling for partial words. It sits directly upstream of the sample pipeline mover in the RX datapath. It takes WIDTH-bit samples from the front-end formatter and hands WIDTH*RATIO-bit words with per-lane keep to the mover and bus stages.

## Interface
- WIDTH, 16, sample width in bits (>=1)
- RATIO, 4, samples per output word (>=2)
- LSB_FIRST, 1, 1: first sample of a word in lane 0 (bits WIDTH-1:0); 0: first sample in lane RATIO-1 (top bits)
- clk  input  1  clock; all logic on rising edge
- rst  input  1  reset, asynchronous, active-low; one clock
- s_in_valid  input  1  input sample valid
- s_in_ready  output  1  input sample accepted when valid && ready
- s_in_data  input  WIDTH  input sample
- s_in_last  input  1  sample is the last of a packet; closes the current word
- flush  input  1  level request to emit the current partial word
- m_out_valid  output  1  output word valid
- m_out_ready  input  1  downstream ready
- m_out_data  output  WIDTH*RATIO  packed word; unfilled lanes are zero
- m_out_keep  output  RATIO  bit k set = lane k holds a sample
- m_out_last  output  1  word closes a packet

## Operation
- State:
  - accumulator acc[WIDTH*RATIO]
  - lane-valid mask amask[RATIO]
  - fill index idx (0..RATIO-1)
  - output register (m_out_*)
- s_in_ready = ~m_out_valid || m_out_ready (output slot free or draining this cycle). This is combinational from registered state and m_out_ready only. It never depends on s_in_valid or s_in_last.
- On input handshake, the sample goes into lane L and sets amask[L]:
  - LSB_FIRST=1: L = idx
  - LSB_FIRST=0: L = RATIO-1-idx
- Word close condition at handshake: idx==RATIO-1 or s_in_last or flush. On close:
  - output register loads data = acc merged with the new sample, keep = amask | new lane, last = s_in_last.
  - acc, amask and idx clear to 0.
- Otherwise idx increments and the output register is unaffected. The output register still clears m_out_valid if it drains this cycle.
- Flush without handshake: flush && s_in_ready && idx!=0 emits the partial word: data = acc, keep = amask, last = 0. acc, amask and idx clear.
  - flush with idx==0 and no handshake is ignored; no empty words are ever emitted.
  - flush while s_in_ready=0 has no effect that cycle. The requester holds flush.
- m_out_valid, data, keep and last stay stable while m_out_valid && !m_out_ready.
- m_out_last=1 always has at least one keep bit set. keep bits are contiguous from the first lane.

## Timing
- Reset (rst low, asynchronous) sets:
  - m_out_valid=0, m_out_data=0, m_out_keep=0, m_out_last=0
  - acc=0, amask=0, idx=0
  - s_in_ready reads 1 after reset.
- Latency: the closing input handshake in cycle N gives m_out_valid=1 in cycle N+1.
- Throughput: one sample per clock sustained with m_out_ready tied high; a word is emitted every RATIO cycles.
- Back-pressure: with the output held (m_out_valid && !m_out_ready), s_in_ready=0 and no samples are accepted, including non-closing ones.
- Simultaneous drain and close: an output handshake and a new word load in the same cycle give back-to-back valid words with no bubble.
- s_in_last in the same cycle as idx==RATIO-1 gives a full word with last=1. No extra empty word follows.
- Reset asserted mid-packet discards the partial word and any pending output word immediately.

## Test plan
- WIDTH=16, RATIO=4, LSB_FIRST=1, m_out_ready=1, input 0x0001..0x0008 back-to-back -> two words:
  - 0x0004_0003_0002_0001, keep=4'b1111, last=0, 1 cycle after 4th input
  - 0x0008_0007_0006_0005, keep=4'b1111, last=0
- LSB_FIRST=0, input 0xA,0xB,0xC,0xD -> word 0x000A_000B_000C_000D, keep=4'b1111.
- Inputs 0x11,0x22 then 0x33 with s_in_last=1 -> word 0x0000_0033_0022_0011, keep=4'b0111, last=1. The next word starts at lane 0.
- flush pulse:
  - after 2 samples with no input -> word keep=4'b0011, last=0
  - flush at idx==0 -> no output word
- m_out_ready=0 for 10 cycles during a continuous input stream -> s_in_ready drops the cycle after the first word is emitted. The output word is held stable. No samples are lost or duplicated after release (scoreboard).
- rst pulled low mid-word (idx=2) and while m_out_valid=1 -> all outputs 0 immediately. The first post-reset word contains only post-reset samples.

Source files
------------

// File: rtl/axis_sample_packer.sv
// -----------------------------------------------------------------------------
// axis_sample_packer
//
// Packs a stream of WIDTH-bit AXI-Stream samples into WIDTH*RATIO-bit words,
// RATIO samples per word. A word closes early on s_in_last or flush, and the
// lanes of a partial word that were never filled read as zero with their keep
// bits cleared.
//
// Parameters
//   WIDTH     sample width in bits (>=1)
//   RATIO     samples per output word (>=2)
//   LSB_FIRST 1: first sample of a word in lane 0; 0: first sample in lane RATIO-1
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   s_in_valid   input sample valid
//   s_in_ready   input sample accepted when valid && ready
//   s_in_data    input sample [WIDTH]
//   s_in_last    sample closes the current word and the packet
//   flush        level request to emit the current partial word
//   m_out_valid  output word valid
//   m_out_ready  downstream ready
//   m_out_data   packed word [WIDTH*RATIO]
//   m_out_keep   per-lane sample-present mask [RATIO]
//   m_out_last   word closes a packet
// -----------------------------------------------------------------------------
module axis_sample_packer #(
    parameter int WIDTH     = 16,
    parameter int RATIO     = 4,
    parameter int LSB_FIRST = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_in_valid,
    output logic                     s_in_ready,
    input  logic [WIDTH-1:0]         s_in_data,
    input  logic                     s_in_last,
    input  logic                     flush,
    output logic                     m_out_valid,
    input  logic                     m_out_ready,
    output logic [WIDTH*RATIO-1:0]   m_out_data,
    output logic [RATIO-1:0]         m_out_keep,
    output logic                     m_out_last
);

    localparam int              IDX_W   = $clog2(RATIO);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(RATIO - 1);

    // Accumulator state
    logic [WIDTH*RATIO-1:0] r_acc;
    logic [RATIO-1:0]       r_amask;
    logic [IDX_W-1:0]       r_idx;

    // Output register
    logic                   r_out_valid;
    logic [WIDTH*RATIO-1:0] r_out_data;
    logic [RATIO-1:0]       r_out_keep;
    logic                   r_out_last;

    logic                   w_ready;
    logic                   w_in_hs;
    logic                   w_close;
    logic                   w_flush_only;
    logic [IDX_W-1:0]       w_lane;
    logic [RATIO-1:0]       w_lane_hit;
    logic [WIDTH*RATIO-1:0] w_merged_data;
    logic [RATIO-1:0]       w_merged_keep;

    // The output slot is free when empty or emptying this cycle; this keeps
    // ready independent of the input side so no combinational loop forms.
    assign w_ready = ~r_out_valid | m_out_ready;
    assign w_in_hs = s_in_valid & w_ready;

    // A handshake closes the word on the last lane, on packet end, or when a
    // flush is pending in the same cycle.
    assign w_close = w_in_hs & ((r_idx == IDX_MAX) | s_in_last | flush);

    // Flush with nothing arriving only emits when something is accumulated.
    assign w_flush_only = ~w_in_hs & flush & w_ready & (r_idx != '0);

    // With LSB_FIRST=0 lanes fill from the top down, so the first sample of a
    // word ends up in the most significant bits.
    assign w_lane = (LSB_FIRST != 0) ? r_idx : (IDX_MAX - r_idx);

    genvar gi;
    generate
        for (gi = 0; gi < RATIO; gi++) begin : g_lane
            assign w_lane_hit[gi] = (w_lane == IDX_W'(gi));
            assign w_merged_data[gi*WIDTH +: WIDTH] =
                w_lane_hit[gi] ? s_in_data : r_acc[gi*WIDTH +: WIDTH];
        end
    endgenerate

    assign w_merged_keep = r_amask | w_lane_hit;

    // Accumulator: fill on non-closing handshakes, clear whenever a word leaves.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc   <= '0;
            r_amask <= '0;
            r_idx   <= '0;
        end else if (w_close || w_flush_only) begin
            r_acc   <= '0;
            r_amask <= '0;
            r_idx   <= '0;
        end else if (w_in_hs) begin
            r_acc   <= w_merged_data;
            r_amask <= w_merged_keep;
            r_idx   <= r_idx + 1'b1;
        end
    end

    // Output register: a new word may load in the same cycle the previous one
    // drains, giving back-to-back words without a bubble. Loads only happen
    // when w_ready is high, so a held word never changes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_keep  <= '0;
            r_out_last  <= 1'b0;
        end else if (w_close) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_merged_data;
            r_out_keep  <= w_merged_keep;
            r_out_last  <= s_in_last;
        end else if (w_flush_only) begin
            r_out_valid <= 1'b1;
            r_out_data  <= r_acc;
            r_out_keep  <= r_amask;
            r_out_last  <= 1'b0;
        end else if (m_out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign s_in_ready  = w_ready;
    assign m_out_valid = r_out_valid;
    assign m_out_data  = r_out_data;
    assign m_out_keep  = r_out_keep;
    assign m_out_last  = r_out_last;

endmodule

// File: tb/tb_axis_sample_packer.sv
// -----------------------------------------------------------------------------
// tb_axis_sample_packer
//
// Directed bench for axis_sample_packer. Two instances share clock and reset:
// dut_l (LSB_FIRST=1) carries most scenarios, dut_m (LSB_FIRST=0) checks lane
// ordering. Inputs change 1 time unit after the rising edge; outputs are
// sampled at that point or after a further 1 unit for combinational ready.
// -----------------------------------------------------------------------------
module tb_axis_sample_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // LSB-first instance
    logic        s_in_valid  = 1'b0;
    logic        s_in_ready;
    logic [15:0] s_in_data   = '0;
    logic        s_in_last   = 1'b0;
    logic        flush       = 1'b0;
    logic        m_out_valid;
    logic        m_out_ready = 1'b1;
    logic [63:0] m_out_data;
    logic [3:0]  m_out_keep;
    logic        m_out_last;

    // MSB-first instance
    logic        b_in_valid  = 1'b0;
    logic        b_in_ready;
    logic [15:0] b_in_data   = '0;
    logic        b_out_valid;
    logic [63:0] b_out_data;
    logic [3:0]  b_out_keep;
    logic        b_out_last;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    axis_sample_packer #(.WIDTH(16), .RATIO(4), .LSB_FIRST(1)) dut_l (
        .clk         (clk),
        .rst         (rst),
        .s_in_valid  (s_in_valid),
        .s_in_ready  (s_in_ready),
        .s_in_data   (s_in_data),
        .s_in_last   (s_in_last),
        .flush       (flush),
        .m_out_valid (m_out_valid),
        .m_out_ready (m_out_ready),
        .m_out_data  (m_out_data),
        .m_out_keep  (m_out_keep),
        .m_out_last  (m_out_last)
    );

    axis_sample_packer #(.WIDTH(16), .RATIO(4), .LSB_FIRST(0)) dut_m (
        .clk         (clk),
        .rst         (rst),
        .s_in_valid  (b_in_valid),
        .s_in_ready  (b_in_ready),
        .s_in_data   (b_in_data),
        .s_in_last   (1'b0),
        .flush       (1'b0),
        .m_out_valid (b_out_valid),
        .m_out_ready (1'b1),
        .m_out_data  (b_out_data),
        .m_out_keep  (b_out_keep),
        .m_out_last  (b_out_last)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d, input logic last);
        s_in_valid = 1'b1;
        s_in_data  = d;
        s_in_last  = last;
        tick();
        s_in_valid = 1'b0;
        s_in_last  = 1'b0;
    endtask

    int          sent;
    int          cyc;
    int          rcv_q[$];
    logic        in_hs;
    logic [63:0] held_word;

    initial begin
        // ---------------- reset state ----------------
        #2 rst = 1'b0;
        #1;
        check("rst_valid", 64'(m_out_valid), 64'd0);
        check("rst_data",  m_out_data,       64'd0);
        check("rst_keep",  64'(m_out_keep),  64'd0);
        check("rst_last",  64'(m_out_last),  64'd0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("rst_ready", 64'(s_in_ready), 64'd1);

        // ---------------- back-to-back full words ----------------
        for (int i = 1; i <= 8; i++) begin
            s_in_valid = 1'b1;
            s_in_data  = 16'(i);
            tick();
            if (i == 3) check("b2b_no_early_word", 64'(m_out_valid), 64'd0);
            if (i == 4) begin
                check("b2b_w0_valid", 64'(m_out_valid), 64'd1);
                check("b2b_w0_data",  m_out_data,       64'h0004_0003_0002_0001);
                check("b2b_w0_keep",  64'(m_out_keep),  64'hf);
                check("b2b_w0_last",  64'(m_out_last),  64'd0);
            end
            if (i == 8) begin
                check("b2b_w1_valid", 64'(m_out_valid), 64'd1);
                check("b2b_w1_data",  m_out_data,       64'h0008_0007_0006_0005);
                check("b2b_w1_keep",  64'(m_out_keep),  64'hf);
            end
        end
        s_in_valid = 1'b0;
        tick();
        check("b2b_drained", 64'(m_out_valid), 64'd0);

        // ---------------- MSB-first lane order ----------------
        for (int i = 0; i < 4; i++) begin
            b_in_valid = 1'b1;
            b_in_data  = 16'(16'hA + i);
            tick();
        end
        b_in_valid = 1'b0;
        check("msb_valid", 64'(b_out_valid), 64'd1);
        check("msb_data",  b_out_data,       64'h000A_000B_000C_000D);
        check("msb_keep",  64'(b_out_keep),  64'hf);
        tick();

        // ---------------- packet end closes a partial word ----------------
        send(16'h11, 1'b0);
        send(16'h22, 1'b0);
        send(16'h33, 1'b1);
        check("last_valid", 64'(m_out_valid), 64'd1);
        check("last_data",  m_out_data,       64'h0000_0033_0022_0011);
        check("last_keep",  64'(m_out_keep),  64'h7);
        check("last_last",  64'(m_out_last),  64'd1);
        send(16'h44, 1'b1);
        check("last_next_lane0_data", m_out_data,      64'h0000_0000_0000_0044);
        check("last_next_lane0_keep", 64'(m_out_keep), 64'h1);
        tick();

        // ---------------- flush ----------------
        send(16'h55, 1'b0);
        send(16'h66, 1'b0);
        check("flush_pre_none", 64'(m_out_valid), 64'd0);
        flush = 1'b1;
        tick();
        check("flush_valid", 64'(m_out_valid), 64'd1);
        check("flush_data",  m_out_data,       64'h0000_0000_0066_0055);
        check("flush_keep",  64'(m_out_keep),  64'h3);
        check("flush_last",  64'(m_out_last),  64'd0);
        tick();
        check("flush_idx0_no_word", 64'(m_out_valid), 64'd0);
        tick();
        check("flush_idx0_still_none", 64'(m_out_valid), 64'd0);
        flush = 1'b0;

        // ---------------- back-pressure scoreboard ----------------
        sent = 0;
        cyc  = 0;
        rcv_q.delete();
        held_word = '0;
        while ((sent < 24 || rcv_q.size() < 24) && cyc < 200) begin
            s_in_valid  = (sent < 24);
            s_in_data   = 16'(16'h100 + sent);
            m_out_ready = !(cyc >= 5 && cyc < 15);
            #1;
            in_hs = s_in_valid && s_in_ready;
            if (cyc == 8) begin
                check("bp_ready_low",  64'(s_in_ready),  64'd0);
                check("bp_held_valid", 64'(m_out_valid), 64'd1);
                check("bp_held_data",  m_out_data,       64'h0107_0106_0105_0104);
                held_word = m_out_data;
            end
            if (cyc == 14) begin
                check("bp_stable_valid", 64'(m_out_valid), 64'd1);
                check("bp_stable_data",  m_out_data,       held_word);
                check("bp_ready_still_low", 64'(s_in_ready), 64'd0);
            end
            if (m_out_valid && m_out_ready) begin
                check("bp_keep", 64'(m_out_keep), 64'hf);
                for (int k = 0; k < 4; k++) rcv_q.push_back(int'(m_out_data[k*16 +: 16]));
            end
            @(posedge clk);
            #1;
            if (in_hs) sent++;
            cyc++;
        end
        s_in_valid  = 1'b0;
        m_out_ready = 1'b1;
        check("bp_count", 64'(rcv_q.size()), 64'd24);
        for (int k = 0; k < rcv_q.size(); k++)
            check($sformatf("bp_sample%0d", k), 64'(rcv_q[k]), 64'(16'h100 + k));
        tick();

        // ---------------- reset mid-word (idx=2) ----------------
        send(16'h701, 1'b0);
        send(16'h702, 1'b0);
        rst = 1'b0;
        #1;
        check("rst_mid_valid", 64'(m_out_valid), 64'd0);
        check("rst_mid_keep",  64'(m_out_keep),  64'd0);
        tick();
        rst = 1'b1;
        send(16'h901, 1'b0);
        send(16'h902, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("rst_mid_post_data", m_out_data,      64'h0000_0000_0902_0901);
        check("rst_mid_post_keep", 64'(m_out_keep), 64'h3);
        tick();

        // ---------------- reset while output held ----------------
        m_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(16'(16'h801 + i), 1'b0);
        check("rst_held_pre_valid", 64'(m_out_valid), 64'd1);
        rst = 1'b0;
        #1;
        check("rst_held_valid", 64'(m_out_valid), 64'd0);
        check("rst_held_data",  m_out_data,       64'd0);
        check("rst_held_keep",  64'(m_out_keep),  64'd0);
        check("rst_held_last",  64'(m_out_last),  64'd0);
        tick();
        rst = 1'b1;
        m_out_ready = 1'b1;
        tick();
        check("rst_held_after_valid", 64'(m_out_valid), 64'd0);
        check("rst_held_after_ready", 64'(s_in_ready),  64'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
